cpu_multicycle: RTL

//   Parametrised multicycle RV32I integer core; successor to the 4-state sb-only CPU.

---
 rtl/cpu_multicycle.sv | 271 +++++++++++++++++++++++++++
 1 files changed

// File: rtl/cpu_multicycle.sv
// Multicycle RV32I/RV32E integer core: FETCH/DECODE/EXECUTE/WRITEBACK sequencing with
// stores issued as ready/valid MMIO writes; anything unsupported parks the core in HALT.
module cpu_multicycle #(
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter int unsigned NUM_REGS = 32,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic [31:0]       imem_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [31:0]       out_addr_o,
  output logic [1:0]        out_size_o,
  output logic [31:0]       out_data_o,
  output logic              halt_o,
  output logic              retire_o
);

  localparam int unsigned RIDX_W = $clog2(NUM_REGS);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_OUT_WAIT, S_WRITEBACK, S_HALT
  } state_e;

  state_e state_q, state_d;

  logic [31:0] pc_q, ir_q, rs1_val_q, rs2_val_q, res_q, npc_q;
  logic        wb_en_q;
  logic [31:0] regs [NUM_REGS];
  logic        out_valid_d, retire_d, halt_d;

  // Instruction fields and immediates
  logic [6:0]  opcode, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign opcode = ir_q[6:0];
  assign rd     = ir_q[11:7];
  assign f3     = ir_q[14:12];
  assign rs1    = ir_q[19:15];
  assign rs2    = ir_q[24:20];
  assign f7     = ir_q[31:25];
  assign imm_i  = {{20{ir_q[31]}}, ir_q[31:20]};
  assign imm_s  = {{20{ir_q[31]}}, ir_q[31:25], ir_q[11:7]};
  assign imm_b  = {{19{ir_q[31]}}, ir_q[31], ir_q[7], ir_q[30:25], ir_q[11:8], 1'b0};
  assign imm_u  = {ir_q[31:12], 12'd0};
  assign imm_j  = {{11{ir_q[31]}}, ir_q[31], ir_q[19:12], ir_q[20], ir_q[30:21], 1'b0};

  logic legal, is_store, uses_rd, uses_rs1, uses_rs2, reg_bad;

  // Legality and register-field usage per opcode; SYSTEM and loads fall to illegal
  always_comb begin
    legal    = 1'b0;
    is_store = 1'b0;
    uses_rd  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OPC_OP: begin
        legal    = (f7 == 7'b0000000) ||
                   ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_OPIMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
      end
      OPC_LUI, OPC_AUIPC, OPC_JAL: begin
        legal   = 1'b1;
        uses_rd = 1'b1;
      end
      OPC_JALR: begin
        legal    = (f3 == 3'b000);
        uses_rd  = 1'b1;
        uses_rs1 = 1'b1;
      end
      OPC_BRANCH: begin
        legal    = (f3 != 3'b010) && (f3 != 3'b011);
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OPC_STORE: begin
        legal    = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
        is_store = 1'b1;
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      default: ;
    endcase
  end

  assign reg_bad = (uses_rd  && (32'(rd)  >= NUM_REGS)) ||
                   (uses_rs1 && (32'(rs1) >= NUM_REGS)) ||
                   (uses_rs2 && (32'(rs2) >= NUM_REGS));

  // Execute-stage ALU, branch compare and next-PC
  logic [31:0] alu_b, alu_res, wb_val, target, st_data;
  logic        alt, br_taken, jumping, misaligned, halt_cond;

  assign alu_b = (opcode == OPC_OP) ? rs2_val_q : imm_i;
  assign alt   = ir_q[30] && ((opcode == OPC_OP) || (f3 == 3'b101));

  always_comb begin
    case (f3)
      3'b000:  alu_res = (alt && opcode == OPC_OP) ? rs1_val_q - alu_b : rs1_val_q + alu_b;
      3'b001:  alu_res = rs1_val_q << alu_b[4:0];
      3'b010:  alu_res = {31'd0, $signed(rs1_val_q) < $signed(alu_b)};
      3'b011:  alu_res = {31'd0, rs1_val_q < alu_b};
      3'b100:  alu_res = rs1_val_q ^ alu_b;
      3'b101:  alu_res = alt ? 32'($signed(rs1_val_q) >>> alu_b[4:0]) : rs1_val_q >> alu_b[4:0];
      3'b110:  alu_res = rs1_val_q | alu_b;
      default: alu_res = rs1_val_q & alu_b;
    endcase
  end

  always_comb begin
    case (f3)
      3'b000:  br_taken = (rs1_val_q == rs2_val_q);
      3'b001:  br_taken = (rs1_val_q != rs2_val_q);
      3'b100:  br_taken = ($signed(rs1_val_q) <  $signed(rs2_val_q));
      3'b101:  br_taken = ($signed(rs1_val_q) >= $signed(rs2_val_q));
      3'b110:  br_taken = (rs1_val_q <  rs2_val_q);
      3'b111:  br_taken = (rs1_val_q >= rs2_val_q);
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    wb_val  = alu_res;
    target  = pc_q + 32'd4;
    jumping = 1'b0;
    case (opcode)
      OPC_LUI:   wb_val = imm_u;
      OPC_AUIPC: wb_val = pc_q + imm_u;
      OPC_JAL: begin
        wb_val  = pc_q + 32'd4;
        target  = pc_q + imm_j;
        jumping = 1'b1;
      end
      OPC_JALR: begin
        wb_val  = pc_q + 32'd4;
        target  = (rs1_val_q + imm_i) & ~32'd1;
        jumping = 1'b1;
      end
      OPC_BRANCH: begin
        if (br_taken) target = pc_q + imm_b;
        jumping = br_taken;
      end
      default: ;
    endcase
  end

  assign misaligned = jumping && target[1];
  assign halt_cond  = !legal || reg_bad || misaligned;

  always_comb begin
    case (f3[1:0])
      2'b00:   st_data = {24'd0, rs2_val_q[7:0]};
      2'b01:   st_data = {16'd0, rs2_val_q[15:0]};
      default: st_data = rs2_val_q;
    endcase
  end

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= S_FETCH;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH:   state_d = S_DECODE;
      S_DECODE:  state_d = S_EXECUTE;
      S_EXECUTE: begin
        if (halt_cond)     state_d = S_HALT;
        else if (is_store) state_d = S_OUT_WAIT;
        else               state_d = S_WRITEBACK;
      end
      S_OUT_WAIT:  if (out_ready_i) state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_FETCH;
      default:     state_d = S_HALT;
    endcase
  end

  // Output logic, registered below so every flag lines up with its state
  always_comb begin
    out_valid_d = 1'b0;
    retire_d    = 1'b0;
    halt_d      = 1'b0;
    case (state_d)
      S_OUT_WAIT:  out_valid_d = 1'b1;
      S_WRITEBACK: retire_d    = 1'b1;
      S_HALT:      halt_d      = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      out_valid_o <= 1'b0;
      retire_o    <= 1'b0;
      halt_o      <= 1'b0;
    end else begin
      out_valid_o <= out_valid_d;
      retire_o    <= retire_d;
      halt_o      <= halt_d;
    end
  end

  // Datapath and register file
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      rs1_val_q  <= '0;
      rs2_val_q  <= '0;
      res_q      <= '0;
      npc_q      <= '0;
      wb_en_q    <= 1'b0;
      out_addr_o <= '0;
      out_size_o <= '0;
      out_data_o <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (state_q)
        S_FETCH:  ir_q <= imem_data_i;
        S_DECODE: begin
          rs1_val_q <= regs[rs1[RIDX_W-1:0]];
          rs2_val_q <= regs[rs2[RIDX_W-1:0]];
        end
        S_EXECUTE: begin
          res_q   <= wb_val;
          npc_q   <= target;
          wb_en_q <= uses_rd && (rd != 5'd0);
          if (is_store && !halt_cond) begin
            out_addr_o <= rs1_val_q + imm_s;
            out_size_o <= f3[1:0];
            out_data_o <= st_data;
          end
        end
        S_WRITEBACK: begin
          pc_q <= npc_q;
          if (wb_en_q) regs[rd[RIDX_W-1:0]] <= res_q;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr_o = pc_q[ADDR_W-1:0];

endmodule
